mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF stage (instruction reads) and the MEM stage
//  (data reads/writes) of the 5-stage mips_32 pipeline. Sequences each access through a fixed-latency

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle shared by the IF port, the MEM port, the arbiter and the unified memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              if_stall;
  logic              mem_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       conflict_cnt;

  // Pipeline and memory side: issues requests, returns memory read data.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, if_stall, mem_stall,
           mem_req, mem_we, mem_addr, mem_wdata, conflict_cnt
  );

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, if_stall, mem_stall,
           mem_req, mem_we, mem_addr, mem_wdata, conflict_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM pipeline ports onto one fixed-latency single-port memory.
// One access at a time: IDLE -> ISSUE -> WAIT -> ACK -> IDLE; outputs other than stalls are flops.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1,
  parameter int RR_MODE = 0
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // WAIT lasts LATENCY cycles, so the down-counter starts at LATENCY-1.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam logic       RR_EN    = (RR_MODE != 32'sd0);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;          // 1 = data port owns the access
  logic              we_q, we_d;
  logic              last_grant_q, last_grant_d; // 1 = data port was served last
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;
  logic              any_req_s, tie_s, pick_d_s;

  // Decide which port wins the IDLE sample; ties go to D or alternate in round-robin mode.
  always_comb begin
    any_req_s = bus.i_req | bus.d_req;
    tie_s     = bus.i_req & bus.d_req;
    pick_d_s  = bus.d_req;
    if (tie_s) begin
      if (RR_EN) begin
        pick_d_s = ~last_grant_q;
      end else begin
        pick_d_s = 1'b1;
      end
    end else begin
      pick_d_s = bus.d_req;
    end
  end

  // State register and all registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      owner_q        <= 1'b0;
      we_q           <= 1'b0;
      last_grant_q   <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      i_ack_q        <= 1'b0;
      d_ack_q        <= 1'b0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
      conflict_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      owner_q        <= owner_d;
      we_q           <= we_d;
      last_grant_q   <= last_grant_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      i_ack_q        <= i_ack_d;
      d_ack_q        <= d_ack_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Next-state sequencing of one memory access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the datapath and the registered strobes for each state.
  always_comb begin
    cnt_d          = cnt_q;
    owner_d        = owner_q;
    we_d           = we_q;
    last_grant_d   = last_grant_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_req_d      = 1'b0;
    mem_we_d       = 1'b0;
    i_ack_d        = 1'b0;
    d_ack_d        = 1'b0;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;
    conflict_cnt_d = conflict_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          // Latch the winner now so later changes on the ports cannot disturb the access.
          owner_d   = pick_d_s;
          we_d      = pick_d_s & bus.d_we;
          mem_req_d = 1'b1;
          mem_we_d  = pick_d_s & bus.d_we;
          if (pick_d_s) begin
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = '0;
          end
        end else begin
          owner_d = owner_q;
        end
        if (tie_s && (conflict_cnt_q != 16'hFFFF)) begin
          conflict_cnt_d = conflict_cnt_q + 16'd1;
        end else begin
          conflict_cnt_d = conflict_cnt_q;
        end
      end
      ST_ISSUE: begin
        cnt_d = CNT_LOAD;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (owner_q) begin
            d_ack_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = bus.mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        last_grant_d = owner_q;
      end
      default: begin
        cnt_d = 4'd0;
      end
    endcase
  end

  assign bus.i_ack        = i_ack_q;
  assign bus.d_ack        = d_ack_q;
  assign bus.i_rdata      = i_rdata_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.conflict_cnt = conflict_cnt_q;
  assign bus.if_stall     = bus.i_req & ~i_ack_q;
  assign bus.mem_stall    = bus.d_req & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LATENCY=1/priority, LATENCY=3/round-robin) checked
// every cycle against a transaction-timeline model, plus directed scenarios and random traffic.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       i_req, d_req, d_we;
  logic [1:0][31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]       o_i_ack, o_d_ack, o_if_stall, o_mem_stall, o_mem_req, o_mem_we;
  logic [1:0][31:0] o_i_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
  logic [1:0][15:0] o_cnt;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    assign bus.i_req     = i_req[g];
    assign bus.i_addr    = i_addr[g];
    assign bus.d_req     = d_req[g];
    assign bus.d_we      = d_we[g];
    assign bus.d_addr    = d_addr[g];
    assign bus.d_wdata   = d_wdata[g];
    assign bus.mem_rdata = mem_rdata[g];
    assign o_i_ack[g]     = bus.i_ack;
    assign o_d_ack[g]     = bus.d_ack;
    assign o_i_rdata[g]   = bus.i_rdata;
    assign o_d_rdata[g]   = bus.d_rdata;
    assign o_if_stall[g]  = bus.if_stall;
    assign o_mem_stall[g] = bus.mem_stall;
    assign o_mem_req[g]   = bus.mem_req;
    assign o_mem_we[g]    = bus.mem_we;
    assign o_mem_addr[g]  = bus.mem_addr;
    assign o_mem_wdata[g] = bus.mem_wdata;
    assign o_cnt[g]       = bus.conflict_cnt;
    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .LATENCY((g == 0) ? 1 : 3), .RR_MODE((g == 0) ? 0 : 1)
    ) dut (
      .clk(clk), .reset(rst), .bus(bus.slave)
    );
  end

  // Reference model: each granted access is a timeline anchored at its grant edge.
  int          nxt[2], gedge[2];
  bit          act[2], own_d[2], m_we[2], last_d[2];
  logic [31:0] m_addr[2], m_wdata[2], e_irdata[2], e_drdata[2];
  logic [15:0] e_cnt[2];
  int          e, total, bad;
  bit          auto_mode;
  string       grants;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int rr_of(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h10) return 32'h2010FFFF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s dut%0d e=%0d got=%0h want=%0h", tag, k, e, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0; nxt[k] = 0; last_d[k] = 1'b0; e_cnt[k] = 16'd0;
      e_irdata[k] = 32'd0; e_drdata[k] = 32'd0;
    end
  endtask

  task automatic model_edge();
    logic pick;
    for (int k = 0; k < 2; k++) begin
      if (!rst && e >= nxt[k] && (i_req[k] | d_req[k])) begin
        if (i_req[k] & d_req[k]) begin
          if (e_cnt[k] != 16'hFFFF) e_cnt[k] = e_cnt[k] + 16'd1;
          pick = (rr_of(k) == 0) ? 1'b1 : !last_d[k];
        end else begin
          pick = d_req[k];
        end
        own_d[k] = pick; act[k] = 1'b1; gedge[k] = e; nxt[k] = e + 3 + lat_of(k);
        m_addr[k] = pick ? d_addr[k] : i_addr[k];
        m_we[k] = pick & d_we[k]; m_wdata[k] = d_wdata[k]; last_d[k] = pick;
      end
    end
  endtask

  task automatic post_edge();
    for (int k = 0; k < 2; k++) begin
      if (act[k] && e == gedge[k] + 1 + lat_of(k)) begin
        if (!own_d[k]) e_irdata[k] = memfn(m_addr[k]);
        else if (!m_we[k]) e_drdata[k] = memfn(m_addr[k]);
      end
      if (act[k] && e == gedge[k] + 2 + lat_of(k)) begin
        if (own_d[k]) d_req[k] = 1'b0;
        else i_req[k] = 1'b0;
      end
      if (auto_mode) begin
        if (!i_req[k] && $urandom_range(1, 0) == 1) begin
          i_req[k] = 1'b1; i_addr[k] = $urandom & 32'hFFFF_FFFC;
        end else if (i_req[k] && $urandom_range(3, 0) == 0) begin
          i_addr[k] = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_req[k] && $urandom_range(1, 0) == 1) begin
          d_req[k] = 1'b1; d_we[k] = 1'($urandom_range(1, 0));
          d_addr[k] = $urandom & 32'hFFFF_FFFC; d_wdata[k] = $urandom;
        end else if (d_req[k] && $urandom_range(3, 0) == 0) begin
          d_we[k] = 1'($urandom_range(1, 0)); d_addr[k] = $urandom & 32'hFFFF_FFFC;
          d_wdata[k] = $urandom;
        end
      end
      if (act[k] && e == gedge[k] + lat_of(k)) mem_rdata[k] = memfn(m_addr[k]);
      else mem_rdata[k] = $urandom;
    end
  endtask

  task automatic check_all();
    logic ia, da, mr;
    for (int k = 0; k < 2; k++) begin
      ia = act[k] && !own_d[k] && (e == gedge[k] + 1 + lat_of(k));
      da = act[k] && own_d[k] && (e == gedge[k] + 1 + lat_of(k));
      mr = act[k] && (e == gedge[k]);
      chk("i_ack", k, o_i_ack[k], ia);
      chk("d_ack", k, o_d_ack[k], da);
      chk("i_rdata", k, o_i_rdata[k], e_irdata[k]);
      chk("d_rdata", k, o_d_rdata[k], e_drdata[k]);
      chk("mem_req", k, o_mem_req[k], mr);
      chk("mem_we", k, o_mem_we[k], mr & m_we[k]);
      chk("conflict_cnt", k, o_cnt[k], e_cnt[k]);
      chk("if_stall", k, o_if_stall[k], i_req[k] & ~ia);
      chk("mem_stall", k, o_mem_stall[k], d_req[k] & ~da);
      if (act[k] && e >= gedge[k] && e <= gedge[k] + lat_of(k)) begin
        chk("mem_addr", k, o_mem_addr[k], m_addr[k]);
        if (m_we[k]) chk("mem_wdata", k, o_mem_wdata[k], m_wdata[k]);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    post_edge();
    #1;
    check_all();
    e++;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_i_ack"}, k, o_i_ack[k], 1'b0);
      chk({tag, "_d_ack"}, k, o_d_ack[k], 1'b0);
      chk({tag, "_i_rdata"}, k, o_i_rdata[k], 32'd0);
      chk({tag, "_d_rdata"}, k, o_d_rdata[k], 32'd0);
      chk({tag, "_mem_req"}, k, o_mem_req[k], 1'b0);
      chk({tag, "_mem_we"}, k, o_mem_we[k], 1'b0);
      chk({tag, "_mem_addr"}, k, o_mem_addr[k], 32'd0);
      chk({tag, "_mem_wdata"}, k, o_mem_wdata[k], 32'd0);
      chk({tag, "_cnt"}, k, o_cnt[k], 16'd0);
      chk({tag, "_stalls"}, k, {o_if_stall[k], o_mem_stall[k]}, 2'b00);
    end
  endtask

  initial begin
    total = 0; bad = 0; e = 0; auto_mode = 1'b0;
    i_req = '0; d_req = '0; d_we = '0; i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("reset");
    #1 rst = 1'b0;

    // Single instruction fetch, LATENCY=1.
    i_req[0] = 1'b1; i_addr[0] = 32'h10;
    for (int s = 0; s < 4; s++) begin
      step();
      if (s == 0) chk("t1_mem_req", 0, o_mem_req[0], 1'b1);
      if (s == 2) chk("t1_i_ack", 0, {o_i_ack[0], o_i_rdata[0]}, {1'b1, 32'h2010FFFF});
    end

    // Simultaneous requests with fixed priority: D first, then I.
    i_req[0] = 1'b1; i_addr[0] = 32'h20; d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h80;
    for (int s = 0; s < 8; s++) begin
      step();
      if (s == 2) chk("t2_d_first", 0, {o_d_ack[0], o_i_ack[0]}, 2'b10);
      if (s == 6) chk("t2_i_then", 0, {o_i_ack[0], o_cnt[0]}, {1'b1, 16'd1});
    end

    // Round-robin with both requests held continuously.
    grants = "";
    i_addr[1] = 32'h100; d_addr[1] = 32'h200; d_we[1] = 1'b0;
    i_req[1] = 1'b1; d_req[1] = 1'b1;
    for (int s = 0; s < 24; s++) begin
      step();
      if (o_d_ack[1]) grants = {grants, "D"};
      if (o_i_ack[1]) grants = {grants, "I"};
      i_req[1] = 1'b1; d_req[1] = 1'b1;
    end
    i_req[1] = 1'b0; d_req[1] = 1'b0;
    total++;
    assert (grants == "DIDI") else begin
      bad++;
      $error("FAIL t3_order got=%s want=DIDI", grants);
    end
    chk("t3_cnt", 1, o_cnt[1], 16'd4);

    // Data write with LATENCY=3: read data register must keep the last read value.
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h40; d_wdata[1] = 32'hDEADBEEF;
    for (int s = 0; s < 6; s++) begin
      step();
      if (s == 0) begin
        chk("t4_mem_we", 1, {o_mem_req[1], o_mem_we[1]}, 2'b11);
        chk("t4_mem_wdata", 1, o_mem_wdata[1], 32'hDEADBEEF);
        chk("t4_mem_addr", 1, o_mem_addr[1], 32'h40);
      end
      if (s == 4) chk("t4_d_ack", 1, o_d_ack[1], 1'b1);
    end
    d_we[1] = 1'b0;
    chk("t4_d_rdata_held", 1, o_d_rdata[1], memfn(32'h200));

    // Reset in the middle of an access on both instances.
    i_req[1] = 1'b1; i_addr[1] = 32'h300; d_req[0] = 1'b1; d_addr[0] = 32'h304;
    step();
    step();
    #3;
    rst = 1'b1; i_req = '0; d_req = '0;
    #1;
    check_all_zero("t5_async");
    model_reset();
    step();
    #3 rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      step();
      chk("t5_no_ack", 0, {o_i_ack, o_d_ack}, 4'b0000);
    end

    // Conflict counter saturation.
    force g_dut[0].dut.conflict_cnt_q = 16'hFFFE;
    force g_dut[1].dut.conflict_cnt_q = 16'hFFFE;
    #1;
    release g_dut[0].dut.conflict_cnt_q;
    release g_dut[1].dut.conflict_cnt_q;
    e_cnt[0] = 16'hFFFE; e_cnt[1] = 16'hFFFE;
    for (int s = 0; s < 18; s++) begin
      i_req = 2'b11; d_req = 2'b11;
      step();
    end
    i_req = '0; d_req = '0;
    chk("t6_sat", 0, o_cnt[0], 16'hFFFF);
    chk("t6_sat", 1, o_cnt[1], 16'hFFFF);
    step();

    // Random traffic with address/data churn while requests are pending.
    auto_mode = 1'b1;
    repeat (1500) step();
    auto_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
